// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, fetches one instruction word at a
// time from instruction memory, and holds it for decode and the branch unit.
// Redirects from the branch unit replace the PC. A bl also captures its
// return address in the link register. There is no prefetch, so a redirect
// never has a wrong-path fetch in flight.
//
// state   | meaning
// S_IDLE  | out of reset, no request outstanding
// S_FETCH | request to memory held at pc until imem_ack
// S_FULL  | instruction buffered and presented to decode
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   link_en,
  output logic [ADDR_WIDTH-1:0]  link_addr,
  output logic [ADDR_WIDTH-1:0]  instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  pc, pc_nxt;
  logic [INSTR_WIDTH-1:0] instr_out_nxt;
  logic [ADDR_WIDTH-1:0]  instr_pc_nxt;
  logic [ADDR_WIDTH-1:0]  link_addr_nxt;
  logic [ADDR_WIDTH-1:0]  instr_count_nxt;

  assign imem_addr = pc;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      link_addr   <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_out   <= instr_out_nxt;
      instr_pc    <= instr_pc_nxt;
      link_addr   <= link_addr_nxt;
      instr_count <= instr_count_nxt;
    end
  end

  // Next-state and decoded outputs; everything holds unless a transition
  // below says otherwise. Acks outside S_FETCH fall through untouched.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_out_nxt   = instr_out;
    instr_pc_nxt    = instr_pc;
    link_addr_nxt   = link_addr;
    instr_count_nxt = instr_count;
    imem_req        = 1'b0;
    instr_valid     = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_out_nxt = imem_rdata;
          instr_pc_nxt  = pc;
          pc_nxt        = pc + ADDR_WIDTH'(1);
          state_nxt     = S_FULL;
        end
      end

      S_FULL: begin
        instr_valid = 1'b1;
        if (redirect_valid) begin
          // A resolved branch consumes the instruction even if decode stalls.
          pc_nxt          = redirect_pc;
          state_nxt       = S_FETCH;
          instr_count_nxt = instr_count + ADDR_WIDTH'(1);
          if (link_en) begin
            link_addr_nxt = instr_pc + ADDR_WIDTH'(1);
          end
        end else if (instr_ready) begin
          // pc already advanced on the fetch, so it is the sequential next PC.
          state_nxt       = S_FETCH;
          instr_count_nxt = instr_count + ADDR_WIDTH'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. Two instances share the clock: one with the
// default reset PC for the main flow, one resetting to the top address for
// wrap-around and mid-fetch reset. Expected (pc, instruction) pairs are queued
// by the stimulus and popped by a monitor at each consume.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance 0: RESET_PC = 0 ----------------
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_en;
  logic [31:0] link_addr;
  logic [31:0] instr_count;

  logic mem_en;
  logic stray_ack;
  int   mem_wait;
  int   wcnt = 0;

  assign imem_ack   = (imem_req && mem_en && (wcnt == 0)) || stray_ack;
  assign imem_rdata = stray_ack ? 32'hDEAD_BEEF : (32'hA000_0000 + imem_addr);

  // Memory wait-state counter: reloads while idle or on ack.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= mem_wait;
    else if (wcnt > 0)         wcnt <= wcnt - 1;
  end

  fetch_sequencer #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_en(link_en), .link_addr(link_addr), .instr_count(instr_count)
  );

  // ---------------- instance 1: RESET_PC = all ones ----------------
  logic        w_rst;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_out;
  logic [31:0] w_ipc;
  logic        w_ready;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_link_en;
  logic [31:0] w_link;
  logic [31:0] w_count;
  logic        w_mem_en;

  assign w_ack   = w_req && w_mem_en;
  assign w_rdata = 32'hA000_0000 + w_addr;

  fetch_sequencer #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFFF)) dut1 (
    .clk(clk), .rst(w_rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_out(w_out), .instr_pc(w_ipc),
    .instr_ready(w_ready),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .link_en(w_link_en), .link_addr(w_link), .instr_count(w_count)
  );

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for instance 0 to present an instruction; the fetch address must
  // stay at a while the request is outstanding.
  task automatic wait_valid0(input logic [31:0] a, output int n);
    n = 0;
    while (!instr_valid && n < 30) begin
      chk("fetch_addr_stable", imem_addr, a);
      chk("fetch_req_held", {31'd0, imem_req}, 32'd1);
      tick();
      n++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid0: timeout, got instr_valid=0 expected 1");
    end
  endtask

  task automatic wait_valid1(output int n);
    n = 0;
    while (!w_valid && n < 30) begin
      tick();
      n++;
    end
    if (!w_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid1: timeout, got instr_valid=0 expected 1");
    end
  endtask

  task automatic consume0();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic consume1();
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
  endtask

  // Scoreboard monitors: compare the presented instruction at each consume.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && instr_valid && (instr_ready || redirect_valid)) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0_unexpected: got pc %h expected none", instr_pc);
      end else begin
        e = q0.pop_front();
        chk("sb0_instr_pc", instr_pc, e.pc);
        chk("sb0_instr_out", instr_out, e.ins);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!w_rst && w_valid && (w_ready || w_redirect)) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_unexpected: got pc %h expected none", w_ipc);
      end else begin
        e = q1.pop_front();
        chk("sb1_instr_pc", w_ipc, e.pc);
        chk("sb1_instr_out", w_out, e.ins);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    link_en = 1'b0; mem_en = 1'b1; stray_ack = 1'b0; mem_wait = 0;
    w_rst = 1'b1; w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
    w_link_en = 1'b0; w_mem_en = 1'b0;

    // 1. reset, then zero-wait sequential fetch
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_link", link_addr, 32'h0);
    chk("rst_count", instr_count, 32'h0);
    tick();
    chk("req_after_release", {31'd0, imem_req}, 32'd1);
    chk("addr_after_release", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{pc: 32'(i), ins: 32'hA000_0000 + 32'(i)});
      wait_valid0(32'(i), n);
      chk("zero_wait_latency", 32'(n), 32'd1);
      consume0();
    end
    chk("count_after_4", instr_count, 32'd4);

    // 2. decode stall, then wait-state memory
    q0.push_back('{pc: 32'h4, ins: 32'hA000_0004});
    wait_valid0(32'h4, n);
    mem_wait = 3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_instr_pc", instr_pc, 32'h4);
      chk("stall_instr_out", instr_out, 32'hA000_0004);
    end
    consume0();
    q0.push_back('{pc: 32'h5, ins: 32'hA000_0005});
    wait_valid0(32'h5, n);
    chk("wait_state_latency", 32'(n), 32'd4);

    // 3. taken branch with decode stalled
    mem_wait = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("branch_req", {31'd0, imem_req}, 32'd1);
    chk("branch_addr", imem_addr, 32'h40);
    chk("branch_count", instr_count, 32'd6);
    q0.push_back('{pc: 32'h40, ins: 32'hA000_0040});
    wait_valid0(32'h40, n);

    // 5a. redirect and link during a fetch are ignored
    mem_wait = 2;
    consume0();
    redirect_valid = 1'b1; redirect_pc = 32'h77; link_en = 1'b1;
    tick();
    chk("fetch_ignore_addr", imem_addr, 32'h41);
    tick();
    chk("fetch_ignore_addr", imem_addr, 32'h41);
    redirect_valid = 1'b0; link_en = 1'b0; mem_wait = 0;
    q0.push_back('{pc: 32'h41, ins: 32'hA000_0041});
    wait_valid0(32'h41, n);
    chk("fetch_ignore_pc", imem_addr, 32'h42);
    chk("fetch_ignore_link", link_addr, 32'h0);
    chk("fetch_ignore_count", instr_count, 32'd7);

    // 5b. stray ack while full
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    chk("stray_instr_out", instr_out, 32'hA000_0041);
    chk("stray_instr_pc", instr_pc, 32'h41);
    chk("stray_valid", {31'd0, instr_valid}, 32'd1);
    chk("stray_pc", imem_addr, 32'h42);

    // 4. bl link capture
    redirect_valid = 1'b1; redirect_pc = 32'h12;
    tick();
    redirect_valid = 1'b0;
    q0.push_back('{pc: 32'h12, ins: 32'hA000_0012});
    wait_valid0(32'h12, n);
    redirect_valid = 1'b1; link_en = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; link_en = 1'b0;
    chk("bl_link", link_addr, 32'h13);
    chk("bl_addr", imem_addr, 32'h100);
    chk("bl_count", instr_count, 32'd9);
    q0.push_back('{pc: 32'h100, ins: 32'hA000_0100});
    wait_valid0(32'h100, n);
    link_en = 1'b1;
    consume0();
    link_en = 1'b0;
    mem_en = 1'b0;
    chk("link_no_redirect", link_addr, 32'h13);
    chk("link_no_redirect_count", instr_count, 32'd10);
    chk("seq_after_link", imem_addr, 32'h101);

    // 6. wrap-around and reset mid-fetch on instance 1
    w_mem_en = 1'b1;
    q1.push_back('{pc: 32'hFFFF_FFFF, ins: 32'h9FFF_FFFF});
    q1.push_back('{pc: 32'h0, ins: 32'hA000_0000});
    w_rst = 1'b0;
    chk("wrap_rst_req", {31'd0, w_req}, 32'd0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFF);
    tick();
    chk("wrap_first_req", {31'd0, w_req}, 32'd1);
    wait_valid1(n);
    consume1();
    chk("wrap_addr_zero", w_addr, 32'h0);
    wait_valid1(n);
    w_mem_en = 1'b0;
    consume1();
    chk("wrap_pending_req", {31'd0, w_req}, 32'd1);
    chk("wrap_pending_addr", w_addr, 32'h1);
    chk("wrap_count", w_count, 32'd2);
    tick();
    w_rst = 1'b1;
    tick();
    chk("midrst_req", {31'd0, w_req}, 32'd0);
    chk("midrst_valid", {31'd0, w_valid}, 32'd0);
    chk("midrst_count", w_count, 32'd0);
    chk("midrst_addr", w_addr, 32'hFFFF_FFFF);
    chk("midrst_instr_pc", w_ipc, 32'h0);
    w_rst = 1'b0;
    tick();
    chk("restart_req", {31'd0, w_req}, 32'd1);
    chk("restart_addr", w_addr, 32'hFFFF_FFFF);
    w_mem_en = 1'b1;
    q1.push_back('{pc: 32'hFFFF_FFFF, ins: 32'h9FFF_FFFF});
    wait_valid1(n);
    consume1();
    chk("restart_count", w_count, 32'd1);

    tick();
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
